dtc_sweep_capture: RTL and testbench

DTC_SWEEP_CAPTURE -- requirements
Module: dtc_sweep_capture

---
 rtl/dtc_pkg.sv | 40 ++++
 rtl/dtc_sweep_capture_sync_ff.sv | 20 ++
 rtl/dtc_sweep_capture.sv | 135 +++++++++++++
 tb/tb_dtc_sweep_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared types and constants for the DTC sweep capture block.
package dtc_pkg;

  typedef enum logic [0:0] {
    WAIT_START,
    SWEEP
  } state_t;

  // One-hot-ish step encoding driven by the upstream sweep generator.
  localparam logic [3:0] PAT_STEP0 = 4'b0000;
  localparam logic [3:0] PAT_STEP1 = 4'b0001;
  localparam logic [3:0] PAT_STEP2 = 4'b0010;
  localparam logic [3:0] PAT_STEP3 = 4'b0100;
  localparam logic [3:0] PAT_STEP4 = 4'b1000;

  localparam logic [2:0] LAST_STEP  = 3'd4;
  localparam logic [2:0] CODE_NOHIT = 3'd5;
  localparam int         NUM_BINS   = 5;

  typedef struct packed {
    logic       ok;
    logic [2:0] step;
  } step_dec_t;

  function automatic step_dec_t decode_step(input logic [3:0] pat);
    step_dec_t r;
    r.ok   = 1'b1;
    r.step = 3'd0;
    case (pat)
      PAT_STEP0: r.step = 3'd0;
      PAT_STEP1: r.step = 3'd1;
      PAT_STEP2: r.step = 3'd2;
      PAT_STEP3: r.step = 3'd3;
      PAT_STEP4: r.step = 3'd4;
      default:   r.ok   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dtc_sweep_capture_sync_ff.sv
// Multi-flop synchronizer for the asynchronous comparator hit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/dtc_sweep_capture.sv
// Captures the first DTC step that produced a comparator hit in each 0..4 sweep.
// Optional per-code hit histogram enabled by defining DTC_CAP_HIST_EN.
module dtc_sweep_capture
  import dtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            d,
  input  logic                  hit_async,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2:0]            res_code,
  output logic                  pat_err,
  output logic                  seq_err,
  output logic                  ovf_err
`ifdef DTC_CAP_HIST_EN
  ,
  output logic [5*CNT_W-1:0]    hist_bin
`endif
);

  logic                   hit_sync;
  logic [3:0]             d_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] v_pipe;

  sync_ff #(.STAGES(SYNC_STAGES)) u_hit_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (hit_async),
    .dout (hit_sync)
  );

  // NOTE: only the valid bits need reset; the d data flops are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) v_pipe <= '0;
    else     v_pipe <= {v_pipe[SYNC_STAGES-2:0], 1'b1};
    d_pipe[0] <= d;
    for (int i = 1; i < SYNC_STAGES; i++) d_pipe[i] <= d_pipe[i-1];
  end

  state_t    state;
  logic [2:0] first_hit;
  logic [2:0] prev_step;
  step_dec_t dec;
  logic      al_valid;
  logic      step_ok;
  logic      done;
  logic      load;
  logic [2:0] fh_next;

  assign al_valid = v_pipe[SYNC_STAGES-1];
  assign dec      = decode_step(d_pipe[SYNC_STAGES-1]);
  assign step_ok  = (dec.step == prev_step + 3'd1);
  assign done     = al_valid && dec.ok && (state == SWEEP) && step_ok && (dec.step == LAST_STEP);
  assign load     = done && (!res_valid || res_ready);

  always_comb begin
    fh_next = first_hit;
    if (hit_sync && first_hit == CODE_NOHIT) fh_next = dec.step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_START;
      first_hit <= CODE_NOHIT;
      prev_step <= 3'd0;
      pat_err   <= 1'b0;
      seq_err   <= 1'b0;
    end else if (al_valid) begin
      if (!dec.ok) begin
        pat_err <= 1'b1;
        state   <= WAIT_START;
      end else begin
        case (state)
          WAIT_START: begin
            if (dec.step == 3'd0) begin
              state     <= SWEEP;
              prev_step <= 3'd0;
              first_hit <= hit_sync ? 3'd0 : CODE_NOHIT;
            end
          end
          SWEEP: begin
            if (!step_ok) begin
              seq_err <= 1'b1;
              state   <= WAIT_START;
            end else if (dec.step == LAST_STEP) begin
              // Back to idle immediately so a step 0 next cycle starts a new sweep.
              state <= WAIT_START;
            end else begin
              prev_step <= dec.step;
              first_hit <= fh_next;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_code  <= 3'd0;
      ovf_err   <= 1'b0;
    end else if (done) begin
      if (load) begin
        res_valid <= 1'b1;
        res_code  <= fh_next;
      end else begin
        ovf_err <= 1'b1;
      end
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef DTC_CAP_HIST_EN
  logic [CNT_W-1:0] bins [NUM_BINS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_BINS; k++) bins[k] <= '0;
    end else if (load && fh_next < CODE_NOHIT) begin
      if (bins[fh_next] != '1) bins[fh_next] <= bins[fh_next] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_BINS; k++) begin : g_hist
    assign hist_bin[k*CNT_W +: CNT_W] = bins[k];
  end
`endif

endmodule

// File: tb/tb_dtc_sweep_capture.sv
// Self-checking bench for dtc_sweep_capture: vector table plus scoreboard of expected codes.
module tb_dtc_sweep_capture;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       d;
  logic             hit_async;
  logic             res_valid;
  logic             res_ready;
  logic [2:0]       res_code;
  logic             pat_err;
  logic             seq_err;
  logic             ovf_err;
`ifdef DTC_CAP_HIST_EN
  logic [5*CNT_W-1:0] hist_bin;
  int               model_bin [5];
`endif

  dtc_sweep_capture #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .hit_async (hit_async),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_code  (res_code),
    .pat_err   (pat_err),
    .seq_err   (seq_err),
    .ovf_err   (ovf_err)
`ifdef DTC_CAP_HIST_EN
    ,
    .hist_bin  (hist_bin)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q [$];

  typedef struct {
    logic [4:0] mask;   // hit_async level per step, bit k = step k
    logic [2:0] code;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return (k == 0) ? 4'b0000 : (one << (k - 1));
  endfunction

  task automatic drive(input logic [3:0] dv, input logic h);
    @(negedge clk);
    d         = dv;
    hit_async = h;
  endtask

  task automatic sweep(input logic [4:0] mask);
    for (int k = 0; k < 5; k++) drive(pat(k), mask[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b1000, 1'b0);
  endtask

`ifdef DTC_CAP_HIST_EN
  task automatic check_bins(input string tag);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_bin%0d", tag, k), 32'(hist_bin[k*CNT_W +: CNT_W]), 32'(model_bin[k]));
  endtask
`endif

  // Scoreboard: every handshake must match the oldest expected code.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && res_valid && res_ready) begin
        check("result_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          logic [2:0] e;
          e = exp_q.pop_front();
          check("res_code", res_code, e);
`ifdef DTC_CAP_HIST_EN
          if (e < 3'd5 && model_bin[e] < (1 << CNT_W) - 1) model_bin[e]++;
`endif
        end
      end
    end
  end

  initial begin
    vec_t vecs [7];
    vecs[0] = '{5'b11100, 3'd2};
    vecs[1] = '{5'b00000, 3'd5};
    vecs[2] = '{5'b11111, 3'd0};
    vecs[3] = '{5'b01000, 3'd3};
    vecs[4] = '{5'b10000, 3'd4};
    vecs[5] = '{5'b00110, 3'd1};
    vecs[6] = '{5'b10010, 3'd1};

    rst       = 1'b1;
    d         = 4'b1000;
    hit_async = 1'b0;
    res_ready = 1'b1;
`ifdef DTC_CAP_HIST_EN
    for (int k = 0; k < 5; k++) model_bin[k] = 0;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_code",  res_code,  0);
    check("rst_pat",   pat_err,   0);
    check("rst_seq",   seq_err,   0);
    check("rst_ovf",   ovf_err,   0);
`ifdef DTC_CAP_HIST_EN
    check_bins("rst");
`endif
    rst = 1'b0;
    idle(4);

    // Back-to-back sweeps from the vector table.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].code);
      sweep(vecs[i].mask);
    end
    idle(6);
    check("drain_vec", exp_q.size(), 0);
    check("vec_pat",   pat_err, 0);
    check("vec_seq",   seq_err, 0);
    check("vec_ovf",   ovf_err, 0);
`ifdef DTC_CAP_HIST_EN
    check_bins("vec");
`endif

    // Latency: res_valid in the third cycle after the d=1000 input cycle, one cycle wide.
    exp_q.push_back(3'd2);
    sweep(5'b11100);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("latency_c%0d", i), res_valid, 32'(i == 3));
    end
    idle(2);
    check("drain_lat", exp_q.size(), 0);

    // Illegal pattern mid-sweep abandons it; the following sweep completes.
    drive(4'b0000, 1'b1);
    drive(4'b0001, 1'b0);
    drive(4'b0110, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b1000, 1'b0);
    idle(4);
    check("pat_no_result", exp_q.size(), 0);
    check("pat_err", pat_err, 1);
    exp_q.push_back(3'd2);
    sweep(5'b00100);
    idle(5);
    check("drain_pat", exp_q.size(), 0);
    check("pat_seq", seq_err, 0);

    // Step skip 1 -> 3 is a sequence error.
    drive(4'b0000, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b1000, 1'b0);
    idle(4);
    check("seq_err", seq_err, 1);
    exp_q.push_back(3'd0);
    sweep(5'b00001);
    idle(5);
    check("drain_seq", exp_q.size(), 0);
    check("seq_ovf", ovf_err, 0);

    // Consumer stalled over two sweeps: first code held, second dropped.
    res_ready = 1'b0;
    exp_q.push_back(3'd1);
    sweep(5'b11110);
    sweep(5'b01000);
    idle(4);
    check("ovf_err",   ovf_err,   1);
    check("ovf_valid", res_valid, 1);
    check("ovf_code",  res_code,  1);
    idle(3);
    check("hold_valid", res_valid, 1);
    check("hold_code",  res_code,  1);
    res_ready = 1'b1;
    @(negedge clk);
    check("ovf_after_hs", res_valid, 0);
    check("drain_ovf", exp_q.size(), 0);
`ifdef DTC_CAP_HIST_EN
    check_bins("ovf");
`endif

    // Reset in the middle of a sweep that already saw a hit at step 1.
    drive(4'b0000, 1'b0);
    drive(4'b0001, 1'b1);
    @(negedge clk);
    rst       = 1'b1;
    d         = 4'b0010;
    hit_async = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_code",  res_code,  0);
    check("mid_rst_pat",   pat_err,   0);
    check("mid_rst_seq",   seq_err,   0);
    check("mid_rst_ovf",   ovf_err,   0);
`ifdef DTC_CAP_HIST_EN
    for (int k = 0; k < 5; k++) model_bin[k] = 0;
    check_bins("mid_rst");
`endif
    rst = 1'b0;
    drive(4'b0100, 1'b0);
    drive(4'b1000, 1'b0);
    idle(4);
    check("post_rst_quiet", res_valid, 0);
    exp_q.push_back(3'd4);
    sweep(5'b10000);
    idle(5);
    check("drain_rst", exp_q.size(), 0);

`ifdef DTC_CAP_HIST_EN
    // Bin 0 saturates after 2^CNT_W+3 code-0 results.
    for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
      exp_q.push_back(3'd0);
      sweep(5'b11111);
    end
    idle(6);
    check("drain_sat", exp_q.size(), 0);
    check("sat_bin0", 32'(hist_bin[CNT_W-1:0]), (1 << CNT_W) - 1);
    check_bins("sat");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
